// File: rtl/pipe_ctrl_if.sv
// Control/status bundle between the pipe_ctrl sequencer (master) and the 5-stage datapath (slave).
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       decode_i_rs1_id;
  logic [4:0]       decode_i_rs2_id;
  logic             decode_i_need_jump;
  logic             decode_i_halt_req;
  logic             regE_i_is_load;
  logic [4:0]       regE_i_wb_rd;
  logic             regE_i_wb_reg_wen;
  logic             dmem_i_req;
  logic             dmem_i_ack;

  logic             fetch_o_stall;
  logic             fetch_o_redirect;
  logic             regD_o_stall;
  logic             regD_o_bubble;
  logic             regE_o_stall;
  logic             regE_o_bubble;
  logic             regM_o_stall;
  logic             regW_o_bubble;
  logic             ctrl_o_halted;
  logic             ctrl_o_timeout;
  logic [CNT_W-1:0] ctrl_o_stall_cnt;

  modport master (
    input  decode_i_rs1_id, decode_i_rs2_id, decode_i_need_jump, decode_i_halt_req,
           regE_i_is_load, regE_i_wb_rd, regE_i_wb_reg_wen, dmem_i_req, dmem_i_ack,
    output fetch_o_stall, fetch_o_redirect, regD_o_stall, regD_o_bubble,
           regE_o_stall, regE_o_bubble, regM_o_stall, regW_o_bubble,
           ctrl_o_halted, ctrl_o_timeout, ctrl_o_stall_cnt
  );

  modport slave (
    output decode_i_rs1_id, decode_i_rs2_id, decode_i_need_jump, decode_i_halt_req,
           regE_i_is_load, regE_i_wb_rd, regE_i_wb_reg_wen, dmem_i_req, dmem_i_ack,
    input  fetch_o_stall, fetch_o_redirect, regD_o_stall, regD_o_bubble,
           regE_o_stall, regE_o_bubble, regM_o_stall, regW_o_bubble,
           ctrl_o_halted, ctrl_o_timeout, ctrl_o_stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the F/D/E/M/W core: interlocks, redirect squash, memory wait with
// watchdog, ebreak drain-to-halt and a saturating stall-cycle counter.
module pipe_ctrl #(
  parameter int TIMEOUT      = 256,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.master bus
);

  localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_HALTED   = 3'd3,
    ST_ERROR    = 3'd4
  } state_t;

  state_t             state_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;
  logic               halted_q;
  logic               timeout_q;

  logic memwait_s;
  logic lduse_s;
  logic fetch_stall_s;
  logic fetch_redirect_s;
  logic regd_stall_s;
  logic regd_bubble_s;
  logic rege_stall_s;
  logic rege_bubble_s;
  logic regm_stall_s;
  logic regw_bubble_s;

  function automatic logic load_use_hazard(
    input logic       is_load,
    input logic       wen,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2
  );
    return is_load & wen & (rd != 5'd0) & ((rd == rs1) | (rd == rs2));
  endfunction

  assign memwait_s = bus.dmem_i_req & ~bus.dmem_i_ack;
  assign lduse_s   = load_use_hazard(bus.regE_i_is_load, bus.regE_i_wb_reg_wen,
                                     bus.regE_i_wb_rd, bus.decode_i_rs1_id,
                                     bus.decode_i_rs2_id);

  // Stage controls: same-cycle decode of the current state and the hazard inputs.
  always_comb begin
    fetch_stall_s    = 1'b0;
    fetch_redirect_s = 1'b0;
    regd_stall_s     = 1'b0;
    regd_bubble_s    = 1'b0;
    rege_stall_s     = 1'b0;
    rege_bubble_s    = 1'b0;
    regm_stall_s     = 1'b0;
    regw_bubble_s    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (memwait_s) begin
          fetch_stall_s = 1'b1;
          regd_stall_s  = 1'b1;
          rege_stall_s  = 1'b1;
          regm_stall_s  = 1'b1;
          regw_bubble_s = 1'b1;
        end else if (lduse_s) begin
          fetch_stall_s = 1'b1;
          regd_stall_s  = 1'b1;
          rege_bubble_s = 1'b1;
        end else if (bus.decode_i_halt_req) begin
          fetch_stall_s = 1'b1;
          regd_bubble_s = 1'b1;
        end else if (bus.decode_i_need_jump) begin
          fetch_redirect_s = 1'b1;
          regd_bubble_s    = 1'b1;
        end else begin
          fetch_redirect_s = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        // The ack cycle already lets the pipeline advance.
        if (!bus.dmem_i_ack) begin
          fetch_stall_s = 1'b1;
          regd_stall_s  = 1'b1;
          rege_stall_s  = 1'b1;
          regm_stall_s  = 1'b1;
          regw_bubble_s = 1'b1;
        end else begin
          fetch_stall_s = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (memwait_s) begin
          fetch_stall_s = 1'b1;
          regd_stall_s  = 1'b1;
          rege_stall_s  = 1'b1;
          regm_stall_s  = 1'b1;
          regw_bubble_s = 1'b1;
        end else begin
          fetch_stall_s = 1'b1;
          regd_bubble_s = 1'b1;
        end
      end
      default: begin
        fetch_stall_s = 1'b1;
        regd_stall_s  = 1'b1;
        rege_stall_s  = 1'b1;
        regm_stall_s  = 1'b1;
        regw_bubble_s = 1'b1;
      end
    endcase
  end

  // Stall counter next value: only live states count, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (fetch_stall_s && (state_q == ST_RUN || state_q == ST_MEM_WAIT || state_q == ST_DRAIN)
        && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Sequencer state, wait/drain counters and sticky status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        ST_RUN: begin
          if (memwait_s) begin
            state_q    <= ST_MEM_WAIT;
            wait_cnt_q <= WAIT_W'(1);
          end else if (!lduse_s && bus.decode_i_halt_req) begin
            state_q     <= ST_DRAIN;
            drain_cnt_q <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (bus.dmem_i_ack) begin
            state_q <= ST_RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q   <= ST_ERROR;
            halted_q  <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_DRAIN: begin
          // Drain progress is frozen while the memory stage is stalled.
          if (!memwait_s) begin
            if (drain_cnt_q == DRAIN_LAST) begin
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end else begin
              drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
            end
          end
        end
        ST_HALTED: begin
          halted_q <= 1'b1;
        end
        ST_ERROR: begin
          halted_q  <= 1'b1;
          timeout_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_ERROR;
          halted_q  <= 1'b1;
          timeout_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.fetch_o_stall    = fetch_stall_s;
  assign bus.fetch_o_redirect = fetch_redirect_s;
  assign bus.regD_o_stall     = regd_stall_s;
  assign bus.regD_o_bubble    = regd_bubble_s;
  assign bus.regE_o_stall     = rege_stall_s;
  assign bus.regE_o_bubble    = rege_bubble_s;
  assign bus.regM_o_stall     = regm_stall_s;
  assign bus.regW_o_bubble    = regw_bubble_s;
  assign bus.ctrl_o_halted    = halted_q;
  assign bus.ctrl_o_timeout   = timeout_q;
  assign bus.ctrl_o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed plus randomized bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;
  localparam int TIMEOUT      = 8;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 32;

  // Control vector order: fstall, redirect, dstall, dbubble, estall, ebubble, mstall, wbubble
  localparam logic [7:0] C_NONE  = 8'h00;
  localparam logic [7:0] C_HOLD  = 8'hAB;
  localparam logic [7:0] C_LDUSE = 8'hA4;
  localparam logic [7:0] C_DRAIN = 8'h90;
  localparam logic [7:0] C_JUMP  = 8'h50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CNT_W)) b ();

  pipe_ctrl #(.TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b.master)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0]       obs_ctrl;
  logic             obs_halted;
  logic             obs_timeout;
  logic [CNT_W-1:0] obs_cnt;

  // Reference model: stalled = memory-stalled cycles so far (0 = none pending),
  // drained = drain cycles completed (-1 = not draining).
  bit          m_halted;
  bit          m_timeout;
  int          m_stalled;
  int          m_drained;
  longint      m_cnt;

  function automatic logic [7:0] dut_ctrl();
    return {b.fetch_o_stall, b.fetch_o_redirect, b.regD_o_stall, b.regD_o_bubble,
            b.regE_o_stall, b.regE_o_bubble, b.regM_o_stall, b.regW_o_bubble};
  endfunction

  function automatic logic model_lduse();
    return b.regE_i_is_load && b.regE_i_wb_reg_wen && (b.regE_i_wb_rd != 5'd0) &&
           (b.regE_i_wb_rd == b.decode_i_rs1_id || b.regE_i_wb_rd == b.decode_i_rs2_id);
  endfunction

  function automatic logic [7:0] model_ctrl();
    logic memwait;
    memwait = b.dmem_i_req && !b.dmem_i_ack;
    if (m_halted) return C_HOLD;
    if (m_stalled > 0) return b.dmem_i_ack ? C_NONE : C_HOLD;
    if (m_drained >= 0) return memwait ? C_HOLD : C_DRAIN;
    if (memwait) return C_HOLD;
    if (model_lduse()) return C_LDUSE;
    if (b.decode_i_halt_req) return C_DRAIN;
    if (b.decode_i_need_jump) return C_JUMP;
    return C_NONE;
  endfunction

  task automatic model_step(input logic [7:0] ctrl);
    logic memwait;
    memwait = b.dmem_i_req && !b.dmem_i_ack;
    if (!m_halted && ctrl[7] && m_cnt != 64'h0000_0000_FFFF_FFFF) m_cnt++;
    if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_stalled > 0) begin
      if (b.dmem_i_ack) m_stalled = 0;
      else begin
        m_stalled++;
        if (m_stalled == TIMEOUT) begin
          m_halted = 1'b1; m_timeout = 1'b1; m_stalled = 0;
        end
      end
    end else if (m_drained >= 0) begin
      if (!memwait) begin
        m_drained++;
        if (m_drained == DRAIN_CYCLES) begin
          m_halted = 1'b1; m_drained = -1;
        end
      end
    end else if (memwait) begin
      m_stalled = 1;
    end else if (!model_lduse() && b.decode_i_halt_req) begin
      m_drained = 0;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic jump,
                       input logic halt, input logic ld, input logic [4:0] rd,
                       input logic wen, input logic req, input logic ack);
    b.decode_i_rs1_id    = rs1;
    b.decode_i_rs2_id    = rs2;
    b.decode_i_need_jump = jump;
    b.decode_i_halt_req  = halt;
    b.regE_i_is_load     = ld;
    b.regE_i_wb_rd       = rd;
    b.regE_i_wb_reg_wen  = wen;
    b.dmem_i_req         = req;
    b.dmem_i_ack         = ack;
  endtask

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic jump,
                      input logic halt, input logic ld, input logic [4:0] rd,
                      input logic wen, input logic req, input logic ack);
    logic [7:0] exp_ctrl;
    @(negedge clk);
    drive(rs1, rs2, jump, halt, ld, rd, wen, req, ack);
    #1;
    obs_ctrl    = dut_ctrl();
    obs_halted  = b.ctrl_o_halted;
    obs_timeout = b.ctrl_o_timeout;
    obs_cnt     = b.ctrl_o_stall_cnt;
    exp_ctrl    = model_ctrl();
    check("ctrl", obs_ctrl, exp_ctrl);
    check("halted", obs_halted, m_halted);
    check("timeout", obs_timeout, m_timeout);
    check("stall_cnt", obs_cnt, m_cnt);
    model_step(exp_ctrl);
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mem(input logic ack);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, ack);
  endtask

  // Reset is raised mid-cycle so its asynchronous effect is checked before any clock edge.
  task automatic apply_reset();
    @(negedge clk);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_ctrl", dut_ctrl(), C_NONE);
    check("rst_halted", b.ctrl_o_halted, 1'b0);
    check("rst_timeout", b.ctrl_o_timeout, 1'b0);
    check("rst_cnt", b.ctrl_o_stall_cnt, 32'd0);
    m_halted = 1'b0; m_timeout = 1'b0; m_stalled = 0; m_drained = -1; m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    longint cnt0;
    int     mstall_hi;
    int     ack_pct;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    apply_reset();

    // load-use on x5, then flow resumes
    step(5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    check("lduse_x5", obs_ctrl, C_LDUSE);
    step(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lduse_resume", obs_ctrl, C_NONE);
    step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    check("lduse_x0", obs_ctrl, C_NONE);
    step(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("jump", obs_ctrl, C_JUMP);
    step(5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check("lduse_jump", obs_ctrl, C_LDUSE);
    step(5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("jump_after", obs_ctrl, C_JUMP);

    // memory access acked after 5 stalled cycles
    cnt0 = m_cnt;
    mstall_hi = 0;
    for (int i = 0; i < 5; i++) begin
      mem(1'b0);
      mstall_hi += int'(obs_ctrl[1]);
    end
    mem(1'b1);
    check("mem_release", obs_ctrl, C_NONE);
    check("mstall_cycles", mstall_hi, 5);
    idle();
    check("mem_cnt", obs_cnt, cnt0 + 5);

    // watchdog: no ack for TIMEOUT stalled cycles
    for (int i = 0; i < TIMEOUT; i++) mem(1'b0);
    check("to_not_yet", obs_timeout, 1'b0);
    idle();
    check("to_fired", obs_timeout, 1'b1);
    check("to_halted", obs_halted, 1'b1);
    check("to_hold", obs_ctrl, C_HOLD);
    apply_reset();

    // ack on the last permitted cycle wins over timeout
    for (int i = 0; i < TIMEOUT - 1; i++) mem(1'b0);
    mem(1'b1);
    check("ack_last_rel", obs_ctrl, C_NONE);
    idle();
    check("ack_last_to", obs_timeout, 1'b0);

    // ebreak: 3 drain cycles then halted
    step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("halt_req", obs_ctrl, C_DRAIN);
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      idle();
      check("drain", obs_ctrl, C_DRAIN);
      check("drain_not_halted", obs_halted, 1'b0);
    end
    idle();
    check("halted", obs_halted, 1'b1);
    check("halted_hold", obs_ctrl, C_HOLD);
    apply_reset();

    // drain frozen by a memory wait, then reset while draining
    step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    mem(1'b0);
    check("drain_memwait", obs_ctrl, C_HOLD);
    mem(1'b1);
    check("drain_ack", obs_ctrl, C_DRAIN);
    apply_reset();

    // randomized traffic against the model
    ack_pct = 50;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) ack_pct = int'($urandom_range(5, 90));
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) apply_reset();
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 4),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 20),
           1'($urandom_range(0, 99) < ack_pct));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
